// File: rtl/calc_pkg.sv
// Shared types and constants for the result display: FSM states, segment
// patterns and the digit-count helper used by the width check.
package calc_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} disp_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   // Active-low gfedcba patterns; index 0 is the rightmost entry.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Decimal digits needed to show 2^bits-1, i.e. ceil(bits*log10(2)).
   function automatic int dec_digits(input int bits);
      longint v;
      int     d;
      v = (longint'(1) << bits) - 1;
      d = 1;
      while (v >= 10) begin
         v = v / 10;
         d++;
      end
      return d;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal nibbles and
// the blank flag both give a dark digit.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (bcd <= 4'd9))
         seg = SEG_TABLE[bcd];
   end

endmodule

// File: rtl/result_display.sv
// Signed-magnitude result to a multiplexed active-low 7-segment display,
// using a one-shift-per-clock double-dabble and leading-zero blanking.
//
//   state   | meaning
//   IDLE    | compare input with shown value, start conversion on difference
//   CONVERT | add-3 / shift one bit per clock, one settle cycle after last shift
//   LOAD    | copy decoded digits and sign into the display registers
module result_display
   import calc_pkg::*;
#(
   parameter int n           = 6,
   parameter int N_DIGITS    = 3,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [n-1:0]        res,
   input  logic                is_negative,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [N_DIGITS-1:0] an,
   output logic                busy
);

   localparam int MAG  = N_DIGITS - 1;
   localparam int BW   = 4 * MAG;
   localparam int CNTW = $clog2(n + 1);
   localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   generate
      if (MAG < dec_digits(n)) begin : g_width_check
         $error("result_display: N_DIGITS-1 too small for an %0d-bit magnitude", n);
      end
   endgenerate

   disp_state_t               state;
   logic                      force_cvt;
   logic [n:0]                shown;
   logic                      lat_neg;
   logic [n-1:0]              lat_mag;
   logic [BW-1:0]             bcd;
   logic [BW-1:0]             bcd_adj;
   logic [n-1:0]              bin;
   logic [CNTW-1:0]           cnt;
   logic [MAG-1:0]            dig_blank;
   logic [MAG-1:0][6:0]       dig_seg;
   logic [6:0]                sign_seg;
   logic [N_DIGITS-1:0][6:0]  disp_pat;
   logic [RW-1:0]             refresh_cnt;
   logic [IW-1:0]             idx;

   assign dp = 1'b1;

   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < MAG; k++) begin
         if (bcd[4*k +: 4] >= 4'd5)
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
   end

   // A digit is blank when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic nz_above;
      dig_blank = '0;
      nz_above  = 1'b0;
      for (int k = MAG - 1; k >= 1; k--) begin
         nz_above     = nz_above | (bcd[4*k +: 4] != 4'd0);
         dig_blank[k] = !nz_above;
      end
   end

   generate
      for (genvar k = 0; k < MAG; k++) begin : g_dec
         seg7_decoder u_dec (
            .bcd   (bcd[4*k +: 4]),
            .blank (dig_blank[k]),
            .seg   (dig_seg[k])
         );
      end
   endgenerate

   assign sign_seg = (lat_neg && (lat_mag != '0)) ? SEG_MINUS : SEG_BLANK;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         force_cvt <= 1'b1;
         shown     <= '0;
         lat_neg   <= 1'b0;
         lat_mag   <= '0;
         bcd       <= '0;
         bin       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         disp_pat  <= {N_DIGITS{SEG_BLANK}};
      end else begin
         case (state)
            IDLE: begin
               if (force_cvt || ({is_negative, res} != shown)) begin
                  lat_neg <= is_negative;
                  lat_mag <= res;
                  bin     <= res;
                  bcd     <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               if (cnt == CNTW'(n)) begin
                  state <= LOAD;
               end else begin
                  bcd <= {bcd_adj[BW-2:0], bin[n-1]};
                  bin <= bin << 1;
                  cnt <= cnt + 1'b1;
               end
            end
            LOAD: begin
               disp_pat[MAG-1:0]      <= dig_seg;
               disp_pat[N_DIGITS-1]   <= sign_seg;
               shown                  <= {lat_neg, lat_mag};
               force_cvt              <= 1'b0;
               busy                   <= 1'b0;
               state                  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // an and seg are registered on the same edge so a digit never shows its neighbour's pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         idx         <= '0;
         seg         <= SEG_BLANK;
         an          <= '1;
      end else begin
         an  <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
         seg <= disp_pat[idx];
         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: reset, conversion timing, sign and
// blanking rules, mid-conversion change, reset abort and scan timing.
module tb_result_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] res = '0;
   logic       is_negative = 1'b0;
   logic [6:0] seg, seg4;
   logic       dp, dp4;
   logic [2:0] an, an4;
   logic       busy, busy4;

   int n_tests = 0;
   int n_fail  = 0;
   int run_len = 0;
   int busy_len = 0;

   always #5 clk = ~clk;

   result_display #(.n(6), .N_DIGITS(3), .REFRESH_DIV(1)) u_dut (
      .clk(clk), .rst(rst), .res(res), .is_negative(is_negative),
      .seg(seg), .dp(dp), .an(an), .busy(busy)
   );

   result_display #(.n(6), .N_DIGITS(3), .REFRESH_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .res(res), .is_negative(is_negative),
      .seg(seg4), .dp(dp4), .an(an4), .busy(busy4)
   );

   // Length of the most recent busy window, in negedge samples.
   always @(negedge clk) begin
      if (busy) run_len++;
      else begin
         if (run_len > 0) busy_len = run_len;
         run_len = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_digit(input string tag, input int k, input logic [6:0] exp);
      logic [2:0] want;
      logic [2:0] one;
      bit found;
      one   = 3'b001;
      want  = ~(one << k);
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (an == want) begin
            found = 1'b1;
            chk(tag, {25'd0, seg}, {25'd0, exp});
         end
      end
      if (!found) chk({tag, "_scan"}, {29'd0, an}, {29'd0, want});
   endtask

   task automatic wait_busy_fall(input string tag);
      bit seen, done;
      seen = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      #1;
   endtask

   task automatic show3(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2);
      chk_digit({tag, "_d0"}, 0, d0);
      chk_digit({tag, "_d1"}, 1, d1);
      chk_digit({tag, "_d2"}, 2, d2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] prev;
      int len, runs, bad;
      bit started;

      // reset held with res=0
      repeat (3) @(negedge clk);
      chk("rst_an",    {29'd0, an},   32'h7);
      chk("rst_seg",   {25'd0, seg},  32'h7F);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_dp",    {31'd0, dp},   32'd1);
      chk("rst_an4",   {29'd0, an4},  32'h7);
      chk("rst_seg4",  {25'd0, seg4}, 32'h7F);
      chk("rst_busy4", {31'd0, busy4}, 32'd0);
      chk("rst_dp4",   {31'd0, dp4},  32'd1);
      rst = 1'b0;
      wait_busy_fall("rst_cvt");
      chk("rst_busy_len", busy_len, 32'd8);
      show3("zero", 7'h40, 7'h7F, 7'h7F);

      // positive single digit
      res = 6'd5; is_negative = 1'b0;
      wait_busy_fall("pos5");
      chk("pos5_busy_len", busy_len, 32'd8);
      show3("pos5", 7'h12, 7'h7F, 7'h7F);

      // negative maximum magnitude
      res = 6'd32; is_negative = 1'b1;
      wait_busy_fall("neg32");
      show3("neg32", 7'h24, 7'h30, 7'h3F);

      // interior zero with a nonzero tens digit
      res = 6'd10; is_negative = 1'b0;
      wait_busy_fall("pos10");
      show3("pos10", 7'h40, 7'h79, 7'h7F);

      // change arrives mid-conversion
      res = 6'd7; is_negative = 1'b0;
      repeat (3) @(negedge clk);
      res = 6'd45;
      wait_busy_fall("mid_first");
      chk("mid_first_len", busy_len, 32'd8);
      chk_digit("mid_first_d0", 0, 7'h78);
      chk_digit("mid_first_d1", 1, 7'h7F);
      wait_busy_fall("mid_second");
      chk("mid_second_len", busy_len, 32'd8);
      show3("mid45", 7'h12, 7'h19, 7'h7F);

      // reset during conversion
      res = 6'd63; is_negative = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_an",   {29'd0, an},   32'h7);
      chk("abort_seg",  {25'd0, seg},  32'h7F);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      wait_busy_fall("abort_restart");
      show3("pos63", 7'h30, 7'h02, 7'h7F);

      // negative zero
      res = 6'd0; is_negative = 1'b1;
      wait_busy_fall("negzero");
      show3("negzero", 7'h40, 7'h7F, 7'h7F);

      // slow scan: each an value held 4 cycles, always exactly one digit active
      prev = an4; len = 0; runs = 0; bad = 0; started = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ($countones(~an4) != 1) bad++;
         if (an4 != prev) begin
            if (started && runs < 4) begin
               chk("scan_hold", len, 32'd4);
               runs++;
            end
            started = 1'b1;
            len = 1;
            prev = an4;
         end else begin
            len++;
         end
      end
      chk("scan_onehot", bad, 32'd0);
      chk("scan_runs", runs, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
